// File: rtl/pc_target_seq.sv
// pc_target_seq: fetch PC register with branch/JAL/JALR target generation,
// I-cache stall hold, queued redirects during stall, and misaligned-target trap.
module pc_target_seq #(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h100,
  parameter bit              ALIGN_CHECK  = 1'b1,
  parameter int unsigned     STALL_CNT_W  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Stall,
  input  logic [1:0]             PCSrc,
  input  logic [WIDTH-1:0]       PCE,
  input  logic [WIDTH-1:0]       SrcA,
  input  logic [WIDTH-1:0]       ImmExt,
  input  logic                   TrapAck,
  output logic [WIDTH-1:0]       PCF,
  output logic [WIDTH-1:0]       PCPlus4F,
  output logic [WIDTH-1:0]       PCTarget,
  output logic                   FetchValid,
  output logic                   Misalign,
  output logic [WIDTH-1:0]       BadAddr,
  output logic [STALL_CNT_W-1:0] StallCnt,
  output logic [1:0]             State
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [WIDTH-1:0]       pcf_n, bad_n, pend, pend_n;
  logic                   fv_n, mis_n, pend_valid, pv_n;
  logic [STALL_CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0]       sum_pc, sum_reg;
  logic                   redirect, misaligned;

  // Target arithmetic, all modulo 2^WIDTH; JALR clears bit 0
  always_comb begin
    sum_pc   = PCE + ImmExt;
    sum_reg  = SrcA + ImmExt;
    sum_reg[0] = 1'b0;
    PCTarget = (PCSrc == 2'b10) ? sum_reg : sum_pc;
    PCPlus4F = PCF + WIDTH'(4);
    redirect   = (PCSrc == 2'b01) || (PCSrc == 2'b10);
    misaligned = ALIGN_CHECK && (PCTarget[1:0] != 2'b00);
  end

  // Next-state and next-output decode
  always_comb begin
    state_n = state;
    pcf_n   = PCF;
    fv_n    = FetchValid;
    mis_n   = Misalign;
    bad_n   = BadAddr;
    cnt_n   = StallCnt;
    pend_n  = pend;
    pv_n    = pend_valid;

    unique case (state)
      S_IDLE: begin
        state_n = S_RUN;
        fv_n    = 1'b1;
      end
      S_RUN: begin
        if (redirect && misaligned) begin
          state_n = S_TRAP;
          pcf_n   = TRAP_VECTOR;
          bad_n   = PCTarget;
          mis_n   = 1'b1;
          fv_n    = 1'b0;
        end else if (redirect) begin
          pcf_n = PCTarget;
        end else if (Stall) begin
          state_n = S_WAIT;
          cnt_n   = STALL_CNT_W'(1);
        end else begin
          pcf_n = PCPlus4F;
        end
      end
      S_WAIT: begin
        if (redirect && misaligned) begin
          state_n = S_TRAP;
          pcf_n   = TRAP_VECTOR;
          bad_n   = PCTarget;
          mis_n   = 1'b1;
          fv_n    = 1'b0;
          pv_n    = 1'b0;
          cnt_n   = '0;
        end else if (!Stall) begin
          // A redirect arriving with stall release outranks the queued one
          state_n = S_RUN;
          cnt_n   = '0;
          pv_n    = 1'b0;
          if (redirect)        pcf_n = PCTarget;
          else if (pend_valid) pcf_n = pend;
          else                 pcf_n = PCPlus4F;
        end else begin
          cnt_n = (&StallCnt) ? StallCnt : StallCnt + STALL_CNT_W'(1);
          if (redirect) begin
            pend_n = PCTarget;
            pv_n   = 1'b1;
          end
        end
      end
      S_TRAP: begin
        if (TrapAck) begin
          state_n = S_RUN;
          mis_n   = 1'b0;
          fv_n    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs, asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      PCF        <= RESET_VECTOR;
      FetchValid <= 1'b0;
      Misalign   <= 1'b0;
      BadAddr    <= '0;
      StallCnt   <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_n;
      PCF        <= pcf_n;
      FetchValid <= fv_n;
      Misalign   <= mis_n;
      BadAddr    <= bad_n;
      StallCnt   <= cnt_n;
      pend       <= pend_n;
      pend_valid <= pv_n;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_pc_target_seq.sv
// Directed testbench for pc_target_seq with hand-computed expectations.
module tb_pc_target_seq;

  logic        CLK, RST, Stall, TrapAck;
  logic [1:0]  PCSrc;
  logic [31:0] PCE, SrcA, ImmExt;
  logic [31:0] PCF, PCPlus4F, PCTarget, BadAddr;
  logic        FetchValid, Misalign;
  logic [7:0]  StallCnt;
  logic [1:0]  State;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_target_seq #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0100),
    .ALIGN_CHECK(1'b1),
    .STALL_CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .PCSrc(PCSrc), .PCE(PCE),
    .SrcA(SrcA), .ImmExt(ImmExt), .TrapAck(TrapAck), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .PCTarget(PCTarget), .FetchValid(FetchValid),
    .Misalign(Misalign), .BadAddr(BadAddr), .StallCnt(StallCnt), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; Stall = 1'b0; TrapAck = 1'b0; PCSrc = 2'b00;
    PCE = '0; SrcA = '0; ImmExt = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pcf", PCF, 32'h0);
    check("rst_fv", {31'b0, FetchValid}, 32'h0);
    check("rst_mis", {31'b0, Misalign}, 32'h0);
    check("rst_bad", BadAddr, 32'h0);
    check("rst_cnt", {24'b0, StallCnt}, 32'h0);
    check("rst_state", {30'b0, State}, 32'h0);

    // 1: sequential fetch 0,0,4,8,C
    RST = 1'b1;
    tick(); check("seq0_pcf", PCF, 32'h0); check("seq0_fv", {31'b0, FetchValid}, 32'h1);
    check("seq0_state", {30'b0, State}, 32'h1);
    tick(); check("seq1_pcf", PCF, 32'h4);
    tick(); check("seq2_pcf", PCF, 32'h8);
    tick(); check("seq3_pcf", PCF, 32'hC);
    check("seq3_plus4", PCPlus4F, 32'h10);

    // 2: branch targets, including wrap-around
    PCE = 32'h0000_AAFC; ImmExt = 32'h1999_0000; PCSrc = 2'b01;
    #1 check("br_tgt", PCTarget, 32'h1999_AAFC);
    tick(); check("br_pcf", PCF, 32'h1999_AAFC);
    PCE = 32'hFFFF_FFFC; ImmExt = 32'h8;
    #1 check("wrap_tgt", PCTarget, 32'h4);
    tick(); check("wrap_pcf", PCF, 32'h4);

    // 3: JALR aligned, then misaligned trap
    PCSrc = 2'b10; SrcA = 32'h6395_1895; ImmExt = 32'h00AA_0003;
    #1 check("jalr_tgt", PCTarget, 32'h643F_1898);
    tick(); check("jalr_pcf", PCF, 32'h643F_1898);
    SrcA = 32'h0000_9852; ImmExt = 32'h0;
    #1 check("jalr_bad_tgt", PCTarget, 32'h9852);
    tick();
    check("trap_mis", {31'b0, Misalign}, 32'h1);
    check("trap_bad", BadAddr, 32'h9852);
    check("trap_pcf", PCF, 32'h100);
    check("trap_fv", {31'b0, FetchValid}, 32'h0);
    check("trap_state", {30'b0, State}, 32'h3);
    PCSrc = 2'b01; PCE = 32'h800; Stall = 1'b1;
    tick(); check("trap_hold_pcf", PCF, 32'h100); check("trap_hold_state", {30'b0, State}, 32'h3);
    PCSrc = 2'b00; Stall = 1'b0; TrapAck = 1'b1;
    tick();
    check("ack_mis", {31'b0, Misalign}, 32'h0);
    check("ack_fv", {31'b0, FetchValid}, 32'h1);
    check("ack_state", {30'b0, State}, 32'h1);
    check("ack_bad_kept", BadAddr, 32'h9852);
    TrapAck = 1'b0;
    tick(); check("ack_adv_pcf", PCF, 32'h104);

    // 4: long stall at 0x40, counter saturation
    PCSrc = 2'b01; PCE = 32'h40; ImmExt = 32'h0;
    tick(); check("go40_pcf", PCF, 32'h40);
    PCSrc = 2'b00; Stall = 1'b1;
    tick(); check("st1_state", {30'b0, State}, 32'h2); check("st1_cnt", {24'b0, StallCnt}, 32'h1);
    check("st1_pcf", PCF, 32'h40);
    repeat (299) tick();
    check("st_sat_cnt", {24'b0, StallCnt}, 32'hFF);
    check("st_sat_pcf", PCF, 32'h40);
    check("st_sat_fv", {31'b0, FetchValid}, 32'h1);
    Stall = 1'b0;
    tick(); check("st_rel_pcf", PCF, 32'h44); check("st_rel_cnt", {24'b0, StallCnt}, 32'h0);
    check("st_rel_state", {30'b0, State}, 32'h1);

    // 5: queued redirect overwritten, then new redirect beats pending
    Stall = 1'b1;
    tick();
    PCSrc = 2'b01; PCE = 32'h200; tick();
    PCE = 32'h300; tick();
    PCSrc = 2'b00; tick(); check("pend_hold_pcf", PCF, 32'h44);
    Stall = 1'b0;
    tick(); check("pend_load_pcf", PCF, 32'h300);
    Stall = 1'b1;
    tick();
    PCSrc = 2'b01; PCE = 32'h200; tick();
    PCE = 32'h500; Stall = 1'b0;
    tick(); check("pend_override_pcf", PCF, 32'h500);

    // 6: async reset mid-WAIT with pending valid
    PCSrc = 2'b00; Stall = 1'b1;
    tick();
    PCSrc = 2'b01; PCE = 32'h600; tick();
    PCSrc = 2'b00;
    #2 RST = 1'b0;
    #1;
    check("arst_pcf", PCF, 32'h0);
    check("arst_state", {30'b0, State}, 32'h0);
    check("arst_fv", {31'b0, FetchValid}, 32'h0);
    Stall = 1'b0;
    tick(); RST = 1'b1;
    check("arst_rel_pcf", PCF, 32'h0);
    tick(); check("post0_pcf", PCF, 32'h0); check("post0_fv", {31'b0, FetchValid}, 32'h1);
    tick(); check("post1_pcf", PCF, 32'h4);
    Stall = 1'b1;
    tick(); check("post_wait_pcf", PCF, 32'h4);
    Stall = 1'b0;
    tick(); check("post_nopend_pcf", PCF, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
